bsg_activation_backward: RTL and testbench
==========================================

BSG_ACTIVATION_BACKWARD -- requirements
Module: bsg_activation_backward

Interface
REQ-001 SHALL have parameter width_p, default 32, giving the data width in bits for y, gradient and result (two's complement, fixed point).
REQ-002 SHALL have parameter frac_p, default 16, giving the number of fraction bits; legal range 1 <= frac_p <= width_p-2; ONE = 2^frac_p.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: synchronous, active-low reset (0 = reset), sampled on clk_i.
REQ-005 SHALL have port y_i, input, width_p bits, signed: forward activation output.
REQ-006 SHALL have port grad_i, input, width_p bits, signed: upstream gradient.
REQ-007 SHALL have port tanh_sel_i, input, 1 bit: 1 selects tanh derivative, 0 selects sigmoid derivative.
REQ-008 SHALL have port val_i, input, 1 bit: input valid.
REQ-009 SHALL have port ready_o, output, 1 bit: the block can accept input.
REQ-010 SHALL have port data_o, output, width_p bits, signed: the result grad_i * f'(y).
REQ-011 SHALL have port val_o, output, 1 bit: data_o is valid.
REQ-012 SHALL have port ready_i, input, 1 bit: the consumer accepts data_o.

Function
REQ-013 SHALL accept an operation on a rising edge where val_i=1 and ready_o=1, registering y_i, grad_i and tanh_sel_i; input changes after acceptance SHALL be ignored.
REQ-014 SHALL implement FSM states IDLE, DERIV, SCALE, FINAL, DONE; ready_o=1 only in IDLE; val_o=1 only in DONE.
REQ-015 SHALL clamp y before use: tanh to [-ONE, ONE], then magnitude |y|; sigmoid to [0, ONE].
REQ-016 SHALL compute d = ONE - ((|y|*|y|) >> frac_p) for tanh and d = (y*(ONE-y)) >> frac_p for sigmoid; d is always in [0, ONE].
REQ-017 SHALL compute result = sign(grad) * ((|grad| * d) >> frac_p), truncating the magnitude toward zero; |grad| SHALL be held in width_p+1 bits so that -2^(width_p-1) is exact; no overflow is possible because d <= ONE.
REQ-018 SHALL perform each multiply with a single shared iterative shift-add unsigned multiplier, one multiplier bit per cycle, width_p cycles per multiply.
REQ-019 SHALL follow these transitions:
- IDLE -> DERIV on accept.
- DERIV -> SCALE after width_p iterations.
- SCALE -> FINAL after width_p iterations.
- FINAL -> DONE, with the sign applied and data_o registered.
- DONE -> IDLE on an edge where ready_i=1.
REQ-020 SHALL bypass the multiplies when d is trivially 0 (tanh with |y| >= ONE; sigmoid with y <= 0 or y >= ONE): IDLE -> DONE on accept, with data_o = 0.
REQ-021 SHALL, on the non-bypass path, assert val_o exactly 2*width_p+2 rising edges after the accepting edge (66 for width_p=32); on the bypass path, exactly 1 edge after.
REQ-022 SHALL hold data_o and val_o stable in DONE while ready_i=0; ready_i SHALL be ignored outside DONE.
REQ-023 SHALL NOT accept a new input in the cycle DONE is exited (ready_o=0 in DONE); the next accept is possible one cycle later.
REQ-024 SHALL treat a zero grad_i like any other value: the full latency applies and data_o = 0.

Reset
REQ-025 SHALL, while reset_i=0 at a rising edge, force state to IDLE, data_o to 0, val_o to 0, ready_o to 1, and clear the multiplier accumulator and iteration counter.
REQ-026 SHALL abandon any in-flight operation on reset (in any state); no stale result SHALL appear after reset_i returns to 1.

Verification (width_p=32, frac_p=16)
REQ-027 SHALL verify: tanh, y=0x00008000, grad=0x00010000 -> data_o=0x0000C000, val_o rises 66 edges after accept.
REQ-028 SHALL verify: sigmoid, y=0x00008000, grad=0x00020000 -> data_o=0x00008000; and tanh, y=0xFFFF8000, grad=0xFFFF0000 -> data_o=0xFFFF4000.
REQ-029 SHALL verify bypass: sigmoid y=0x00010000 and tanh y=0x00018000 (grad=0x00050000) -> data_o=0, val_o one edge after accept; sigmoid y=0xFFFFF000 -> data_o=0.
REQ-030 SHALL verify backpressure: ready_i held 0 for 10 cycles in DONE -> val_o=1 and data_o constant, ready_o=0; then ready_i=1 -> IDLE next edge, and a back-to-back op is accepted one cycle later.
REQ-031 SHALL verify reset mid-operation: reset_i=0 for one edge at the 20th DERIV cycle -> val_o=0, ready_o=1, data_o=0 next cycle; the following op (tanh, y=0, grad=0x80000000) -> data_o=0x80000000.

Source files
------------

// File: rtl/bsg_activation_backward.sv
// Backward pass of tanh/sigmoid in fixed point: data_o = grad * f'(y), where
// f'(y) is derived from the forward output y, using one shared shift-add multiplier.
module bsg_activation_backward #(
  parameter int width_p = 32,
  parameter int frac_p  = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] y_i,
  input  logic [width_p-1:0] grad_i,
  input  logic               tanh_sel_i,
  input  logic               val_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               val_o,
  input  logic               ready_i
);

  localparam int PW = 2 * width_p + 1;
  localparam int CW = $clog2(width_p);
  localparam logic [CW-1:0] LAST = CW'(width_p - 1);
  localparam logic [width_p-1:0] ONE = width_p'(1) << frac_p;
  localparam logic signed [width_p-1:0] ONE_S     = $signed(ONE);
  localparam logic signed [width_p-1:0] NEG_ONE_S = -ONE_S;

  typedef enum logic [2:0] {IDLE, DERIV, SCALE, FINAL, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [width_p-1:0] mplier_q, mplier_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [width_p:0]   gmag_q, gmag_d;
  logic               gneg_q, gneg_d;
  logic               tanh_q, tanh_d;
  logic [width_p-1:0] data_q, data_d;

  logic signed [width_p-1:0] y_s, y_t;
  logic [width_p-1:0] y_c, d_val;
  logic [width_p:0]   g_ext, mag;
  logic [PW-1:0]      mul_sum;
  logic               bypass;

  // Clamp the incoming activation and decide whether the derivative is trivially zero.
  always_comb begin
    y_s = $signed(y_i);
    y_t = y_s;
    y_c = '0;
    bypass = 1'b0;
    if (tanh_sel_i) begin
      if (y_s > ONE_S)          y_t = ONE_S;
      else if (y_s < NEG_ONE_S) y_t = NEG_ONE_S;
      y_c    = y_t[width_p-1] ? $unsigned(-y_t) : $unsigned(y_t);
      bypass = (y_c == ONE);
    end else begin
      if (y_s[width_p-1])   y_c = '0;
      else if (y_s > ONE_S) y_c = ONE;
      else                  y_c = $unsigned(y_s);
      bypass = y_s[width_p-1] || (y_s == '0) || (y_s >= ONE_S);
    end
    g_ext = {grad_i[width_p-1], grad_i};
  end

  // One multiplier bit per cycle: add the shifted multiplicand when the LSB is set.
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    gmag_d   = gmag_q;
    gneg_d   = gneg_q;
    tanh_d   = tanh_q;
    data_d   = data_q;
    d_val    = '0;
    mag      = (width_p+1)'(acc_q >> frac_p);

    unique case (state_q)
      IDLE: begin
        if (val_i) begin
          tanh_d = tanh_sel_i;
          gneg_d = grad_i[width_p-1];
          gmag_d = grad_i[width_p-1] ? -g_ext : g_ext;
          if (bypass) begin
            data_d  = '0;
            state_d = DONE;
          end else begin
            mcand_d  = PW'(y_c);
            mplier_d = tanh_sel_i ? y_c : (ONE - y_c);
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = DERIV;
          end
        end
      end
      DERIV: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          d_val    = tanh_q ? (ONE - width_p'(mul_sum >> frac_p)) : width_p'(mul_sum >> frac_p);
          mcand_d  = PW'(gmag_q);
          mplier_d = d_val;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = SCALE;
        end
      end
      SCALE: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = FINAL;
        end
      end
      FINAL: begin
        // Magnitude truncates toward zero; the sign goes back on afterwards.
        data_d  = width_p'(gneg_q ? -mag : mag);
        state_d = DONE;
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      gmag_q   <= '0;
      gneg_q   <= 1'b0;
      tanh_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      gmag_q   <= gmag_d;
      gneg_q   <= gneg_d;
      tanh_q   <= tanh_d;
      data_q   <= data_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign val_o   = (state_q == DONE);
  assign data_o  = data_q;

endmodule

// File: tb/tb_bsg_activation_backward.sv
// Scoreboard bench for bsg_activation_backward (width_p=32, frac_p=16): expected
// results are queued at drive time and compared when val_o appears.
module tb_bsg_activation_backward;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] y_i, grad_i;
  logic        tanh_sel_i, val_i, ready_i;
  logic        ready_o, val_o;
  logic [31:0] data_o;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } sb_item_t;

  sb_item_t sb[$];
  int n_vec  = 0;
  int n_miss = 0;

  bsg_activation_backward #(.width_p(32), .frac_p(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .y_i(y_i), .grad_i(grad_i),
    .tanh_sel_i(tanh_sel_i), .val_i(val_i), .ready_o(ready_o),
    .data_o(data_o), .val_o(val_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model straight from the derivative formulas, in wide integers.
  function automatic logic [31:0] model(input logic t, input logic [31:0] y, input logic [31:0] g);
    longint one = 65536;
    longint yy  = longint'($signed(y));
    longint gg  = longint'($signed(g));
    longint a, d, mag;
    if (t) begin
      if (yy > one)  yy = one;
      if (yy < -one) yy = -one;
      a = (yy < 0) ? -yy : yy;
      d = one - ((a * a) >>> 16);
    end else begin
      if (yy < 0)   yy = 0;
      if (yy > one) yy = one;
      d = (yy * (one - yy)) >>> 16;
    end
    mag = (((gg < 0) ? -gg : gg) * d) >>> 16;
    return (gg < 0) ? 32'(-mag) : 32'(mag);
  endfunction

  function automatic int model_lat(input logic t, input logic [31:0] y);
    longint one = 65536;
    longint yy  = longint'($signed(y));
    if (t) return (yy >= one || yy <= -one) ? 1 : 66;
    return (yy <= 0 || yy >= one) ? 1 : 66;
  endfunction

  task automatic drive(input logic t, input logic [31:0] y, input logic [31:0] g);
    @(negedge clk_i);
    tanh_sel_i = t;
    y_i        = y;
    grad_i     = g;
    val_i      = 1'b1;
  endtask

  // Latency counts edges with the accepting edge as edge 1.
  task automatic run_op(input string tag, input logic t, input logic [31:0] y, input logic [31:0] g,
                        input logic [31:0] exp, input int exp_lat, input int hold);
    sb_item_t it;
    int lat;
    sb.push_back('{data: exp, lat: exp_lat});
    drive(t, y, g);
    ready_i = (hold == 0);
    check({tag, "_ready_idle"}, 64'(ready_o), 64'd1);
    @(posedge clk_i); #1;
    val_i      = 1'b0;
    y_i        = $urandom;
    grad_i     = $urandom;
    tanh_sel_i = 1'($urandom);
    lat = 1;
    while (!val_o && lat < 300) begin
      @(posedge clk_i); #1;
      lat++;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      it = sb.pop_front();
      check({tag, "_lat"}, 64'(lat), 64'(it.lat));
      check({tag, "_data"}, 64'(data_o), 64'(it.data));
      check({tag, "_ready_done"}, 64'(ready_o), 64'd0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk_i); #1;
        check({tag, "_hold_val"}, 64'(val_o), 64'd1);
        check({tag, "_hold_data"}, 64'(data_o), 64'(it.data));
        check({tag, "_hold_ready"}, 64'(ready_o), 64'd0);
      end
    end
    if (hold == 0) begin
      @(posedge clk_i); #1;
      check({tag, "_exit_ready"}, 64'(ready_o), 64'd1);
      check({tag, "_exit_val"}, 64'(val_o), 64'd0);
    end
  endtask

  initial begin
    int stale;
    logic        rt;
    logic [31:0] ry, rg;

    reset_i = 1'b0; val_i = 1'b0; ready_i = 1'b1;
    y_i = '0; grad_i = '0; tanh_sel_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_val",   64'(val_o),   64'd0);
    check("rst_data",  64'(data_o),  64'd0);
    @(negedge clk_i) reset_i = 1'b1;

    run_op("tanh_half",   1'b1, 32'h0000_8000, 32'h0001_0000, 32'h0000_C000, 66, 0);
    run_op("sig_half",    1'b0, 32'h0000_8000, 32'h0002_0000, 32'h0000_8000, 66, 0);
    run_op("tanh_neg",    1'b1, 32'hFFFF_8000, 32'hFFFF_0000, 32'hFFFF_4000, 66, 0);
    run_op("sig_byp_one", 1'b0, 32'h0001_0000, 32'h0005_0000, 32'h0000_0000, 1, 0);
    run_op("tanh_byp",    1'b1, 32'h0001_8000, 32'h0005_0000, 32'h0000_0000, 1, 0);
    run_op("sig_byp_neg", 1'b0, 32'hFFFF_F000, 32'h0005_0000, 32'h0000_0000, 1, 0);
    run_op("tanh_byp_m1", 1'b1, 32'hFFFF_0000, 32'h0005_0000, 32'h0000_0000, 1, 0);
    run_op("sig_byp_0",   1'b0, 32'h0000_0000, 32'h0005_0000, 32'h0000_0000, 1, 0);
    run_op("sig_lsb",     1'b0, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 66, 0);
    run_op("zero_grad",   1'b1, 32'h0000_4000, 32'h0000_0000, 32'h0000_0000, 66, 0);

    // Backpressure, then a back-to-back op presented while DONE is exited.
    run_op("bp", 1'b1, 32'h0000_8000, 32'h0001_0000, 32'h0000_C000, 66, 10);
    @(negedge clk_i);
    ready_i = 1'b1;
    tanh_sel_i = 1'b0; y_i = 32'h0000_8000; grad_i = 32'h0002_0000; val_i = 1'b1;
    check("bp_exit_ready_before", 64'(ready_o), 64'd0);
    @(posedge clk_i); #1;
    check("bp_exit_ready", 64'(ready_o), 64'd1);
    check("bp_exit_val",   64'(val_o),   64'd0);
    run_op("b2b", 1'b0, 32'h0000_8000, 32'h0002_0000, 32'h0000_8000, 66, 0);

    // Reset in the 20th DERIV cycle; the in-flight result must never appear.
    sb.push_back('{data: 32'h0000_C000, lat: 66});
    drive(1'b1, 32'h0000_8000, 32'h0001_0000);
    @(posedge clk_i); #1;
    val_i = 1'b0;
    repeat (19) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    sb.delete();
    check("mid_rst_val",   64'(val_o),   64'd0);
    check("mid_rst_ready", 64'(ready_o), 64'd1);
    check("mid_rst_data",  64'(data_o),  64'd0);
    stale = 0;
    repeat (80) begin
      @(posedge clk_i); #1;
      if (val_o) stale = 1;
    end
    check("no_stale", 64'(stale), 64'd0);
    run_op("min_grad", 1'b1, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 66, 0);

    for (int i = 0; i < 8; i++) begin
      rt = 1'(i);
      ry = 32'(int'($urandom_range(32'h30000, 0)) - 32'sh18000);
      rg = $urandom;
      run_op("rand", rt, ry, rg, model(rt, ry, rg), model_lat(rt, ry), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
